// File: rtl/stdin_word_buffer_if.sv
// Byte-in / word-out handshake bundle for the stdin word buffer.
// Slave is the buffer; master is the byte source plus word consumer.
interface stdin_word_buffer_if;
  logic        byte_val;
  logic [7:0]  byte_data;
  logic        byte_rdy;
  logic        word_val;
  logic [15:0] word_data;
  logic        word_rdy;

  modport slave (
    input  byte_val,
    input  byte_data,
    output byte_rdy,
    output word_val,
    output word_data,
    input  word_rdy
  );

  modport master (
    output byte_val,
    output byte_data,
    input  byte_rdy,
    input  word_val,
    input  word_data,
    output word_rdy
  );
endinterface

// File: rtl/stdin_word_buffer.sv
// Packs received bytes into 16-bit words (high byte first) and queues
// them in a small fall-through FIFO feeding the LSU stdin port.
module stdin_word_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  stdin_word_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   half_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    HI_BYTE = 1'b0,
    LO_BYTE = 1'b1
  } phase_t;

  phase_t        phase_q;
  phase_t        phase_d;
  logic [7:0]    hi_q;
  logic [7:0]    hi_d;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          byte_fire;
  logic          push;
  logic          pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign byte_fire = bus.byte_val && bus.byte_rdy;
  assign pop       = bus.word_val && bus.word_rdy;

  assign bus.byte_rdy  = (phase_q == HI_BYTE) || !full;
  assign bus.word_val  = (count != '0);
  assign bus.word_data = mem[rd_ptr];
  assign count_o       = count;
  assign half_o        = (phase_q == LO_BYTE);

  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    push    = 1'b0;
    unique case (phase_q)
      HI_BYTE: begin
        if (byte_fire) begin
          hi_d    = bus.byte_data;
          phase_d = LO_BYTE;
        end
      end
      LO_BYTE: begin
        if (byte_fire) begin
          push    = 1'b1;
          phase_d = HI_BYTE;
        end
      end
      default: phase_d = HI_BYTE;
    endcase
  end

  // Flush wins over any handshake in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= HI_BYTE;
      hi_q    <= '0;
    end else if (flush_i) begin
      phase_q <= HI_BYTE;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push)
      mem[wr_ptr] <= {hi_q, bus.byte_data};
  end

endmodule

// File: tb/tb_stdin_word_buffer.sv
// Randomized and directed bench for stdin_word_buffer against a
// queue-based reference model.
module tb_stdin_word_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] count;
  logic       half;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] q [$];
  logic        m_half;
  logic [7:0]  m_hi;

  stdin_word_buffer_if bus ();

  stdin_word_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus.slave),
    .count_o (count),
    .half_o  (half)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic rdy;
    logic pop;
    if (rst || flush) begin
      q.delete();
      m_half = 1'b0;
      if (rst) m_hi = 8'h00;
    end else begin
      rdy = !m_half || (q.size() != DEPTH);
      pop = (q.size() > 0) && bus.word_rdy;
      if (pop) void'(q.pop_front());
      if (bus.byte_val && rdy) begin
        if (!m_half) begin
          m_hi   = bus.byte_data;
          m_half = 1'b1;
        end else begin
          q.push_back({m_hi, bus.byte_data});
          m_half = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("byte_rdy", 32'(bus.byte_rdy),
          32'(!m_half || (q.size() != DEPTH)));
    check("word_val", 32'(bus.word_val), 32'(q.size() != 0));
    check("count", 32'(count), 32'(q.size()));
    check("half", 32'(half), 32'(m_half));
    if (q.size() != 0)
      check("word_data", 32'(bus.word_data), 32'(q[0]));
  endtask

  task automatic cycle(input logic bv, input logic [7:0] bd,
                       input logic wr, input logic fl, input logic rs);
    bus.byte_val  = bv;
    bus.byte_data = bd;
    bus.word_rdy  = wr;
    flush         = fl;
    rst           = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic put_word(input logic [15:0] w, input logic wr);
    cycle(1'b1, w[15:8], wr, 1'b0, 1'b0);
    cycle(1'b1, w[7:0], wr, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic wr);
    cycle(1'b0, 8'h00, wr, 1'b0, 1'b0);
  endtask

  initial begin
    q.delete();
    m_half = 1'b0;
    m_hi   = 8'h00;
    bus.byte_val  = 1'b0;
    bus.byte_data = 8'h00;
    bus.word_rdy  = 1'b0;
    @(negedge clk);

    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rst_rdy", 32'(bus.byte_rdy), 32'd1);
    check("rst_val", 32'(bus.word_val), 32'd0);
    check("rst_cnt", 32'(count), 32'd0);

    cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    check("first_half", 32'(half), 32'd1);
    check("first_val", 32'(bus.word_val), 32'd0);
    cycle(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    check("first_word", 32'(bus.word_data), 32'h1234);
    check("first_cnt", 32'(count), 32'd1);

    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) put_word(16'hA000 + 16'(i), 1'b0);
    check("full_cnt", 32'(count), 32'd4);
    cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    check("full_hi", 32'(half), 32'd1);
    check("full_stall", 32'(bus.byte_rdy), 32'd0);
    cycle(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
    check("full_stall2", 32'(bus.byte_rdy), 32'd0);
    cycle(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    check("after_pop_rdy", 32'(bus.byte_rdy), 32'd1);
    cycle(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
    check("bb_pushed_cnt", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("bbcc_seen", 32'(q.size()), 32'd0);

    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) put_word(16'(i), 1'b0);
    for (int i = 1; i <= 4; i++) begin
      check("order", 32'(bus.word_data), 32'(i));
      idle(1'b1);
    end
    check("drained", 32'(bus.word_val), 32'd0);

    for (int i = 0; i < 6; i++) begin
      put_word(16'hC000 + 16'(i), 1'b0);
      check("wrap", 32'(bus.word_data), 32'hC000 + 32'(i));
      idle(1'b1);
    end

    put_word(16'h1111, 1'b0);
    put_word(16'h2222, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    check("steady_cnt", 32'(count), 32'd2);
    check("steady_head", 32'(bus.word_data), 32'h2222);

    for (int r = 0; r < 2; r++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) put_word(16'h9000 + 16'(i), 1'b0);
      cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hFF, 1'b1, (r == 0), (r == 1));
      check("fl_cnt", 32'(count), 32'd0);
      check("fl_half", 32'(half), 32'd0);
      check("fl_val", 32'(bus.word_val), 32'd0);
      put_word(16'h5678, 1'b0);
      check("fl_word", 32'(bus.word_data), 32'h5678);
    end

    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode = (i / 500) % 3;
      cycle(($urandom_range(0, 3) != 0),
            8'($urandom),
            (mode == 0) ? ($urandom_range(0, 3) == 0) :
            (mode == 1) ? ($urandom_range(0, 1) == 0) :
                          ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 499) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
